rf_forward_unit: RTL and testbench
==================================

# rf_forward_unit

Register file with integrated writeback tracking, operand forwarding and load-use detection for the pipelined miniRV core. It consumes the writeback value chosen by the writeback mux (`wb_wd`) and returns operands to the decode stage. It tracks the destination tag of each in-flight instruction through EX, MEM and WB, and bypasses the newest matching result onto the two read ports. It raises a stall when a decode-stage operand depends on a load that is still in EX.

## Interface
Parameters:
- `NREG`, 32: number of architectural registers; x0 is hardwired to zero.
- `XLEN`, 32: data width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `id_valid`  in  1  the decode stage holds a real instruction.
- `id_rs1`, `id_rs2`  in  5 each  source register indices.
- `id_rs1_used`, `id_rs2_used`  in  1 each  the operand is actually read; unused operands never cause a stall.
- `id_rd`  in  5  destination index.
- `id_we`  in  1  the instruction writes `id_rd`.
- `id_wsel`  in  2  writeback select: 00 ALU, 01 MEM, 10 PC4, 11 IMM.
- `flush`  in  1  kill the decode-stage instruction (taken branch or jump).
- `ex_wd`  in  XLEN  EX-stage result, already selected for ALU, PC4 or IMM.
- `mem_wd`  in  XLEN  MEM-stage result, with load data already merged.
- `wb_wd`  in  XLEN  writeback-mux output for the WB-stage instruction.
- `rD1`, `rD2`  out  XLEN  forwarded operands (combinational).
- `load_use_stall`  out  1  hold PC and IF/ID; this block inserts a bubble into EX.
- `wb_we`  out  1  WB-stage write enable actually applied, for debug and trace.
- `wb_rd`  out  5  WB-stage destination, for debug and trace.

## Operation
- Internal tag pipeline: three stages, EX, MEM and WB. Each stage holds `{v, rd, we, wsel}`.
- At each rising edge:
  - EX ← decode fields when `id_valid & ~flush & ~load_use_stall`; otherwise EX ← bubble (v=0).
  - MEM ← EX.
  - WB ← MEM.
- A stage "writes r" when v & we & rd==r & r!=0.
- Register file: 32×XLEN. At the rising edge, it is written with `wb_wd` at `wb_rd` when the WB stage writes `wb_rd`. Writes to x0 are discarded.
- Read priority for each port, with rs = `id_rs1` or `id_rs2`:
  1. rs==0 → 0.
  2. EX writes rs and EX.wsel!=01 → `ex_wd`.
  3. EX writes rs and EX.wsel==01 → register-file value; the stall is asserted and this value is don't-care.
  4. MEM writes rs → `mem_wd`.
  5. WB writes rs → `wb_wd` (same-cycle write bypass).
  6. Otherwise → register-file contents.
- `load_use_stall` = `id_valid` & ~`flush` & ((`id_rs1_used` & EX writes `id_rs1` with wsel 01) | (`id_rs2_used` & EX writes `id_rs2` with wsel 01)).
- `flush` has priority over the stall. When both conditions are true, the stall output is 0 and a bubble enters EX.
- `wb_we` = WB.v & WB.we & (WB.rd!=0). `wb_rd` = WB.rd.

## Timing
- Reset, asynchronous: all stage v=0, all registers = 0. Outputs: `rD1`=`rD2`=0, `load_use_stall`=0, `wb_we`=0, `wb_rd`=0.
- Reset takes effect immediately, even mid-operation; in-flight writes are dropped.
- Latency: an instruction accepted in cycle n is in EX at n+1, MEM at n+2 and WB at n+3. Its register-file write commits at the end of n+3.
  - The result is visible via bypass from n+1 (non-load) or n+2 (load).
  - The result is visible from storage from n+4.
- A load-use dependency costs exactly one stall cycle. The next cycle the load is in MEM and `mem_wd` is forwarded.
- When several stages match the same rs, the youngest stage wins: EX over MEM over WB.
- `rD*` and `load_use_stall` are purely combinational from inputs and state; there is no added cycle.

## Test plan
- Reset then read: assert `rst` mid-run with WB writing x5 → `rD1`=0 for rs1=5 after reset; `wb_we`=0.
- Back-to-back ALU: issue `addi x1` with `ex_wd`=0x11, next instruction reads x1 → `rD1`=0x11 in that cycle, no stall.
- Load-use: a load to x2 in EX, next instruction reads x2 (used=1) → `load_use_stall`=1 for one cycle. The following cycle `rD2`=`mem_wd`=0xDEADBEEF and the stall is 0.
- Priority: EX, MEM and WB all write x3 with values 0xA, 0xB and 0xC → `rD1`=0xA. Kill EX (flush upstream) and advance → `rD1`=0xA now from MEM, and so on down to the register file.
- x0 and unused operands: write x0 with 0xFF, read x0 → 0. A load to x4 in EX with `id_rs1`=4 and `id_rs1_used`=0 → no stall.
- Flush with stall: load-use condition and `flush`=1 together → `load_use_stall`=0. EX holds a bubble next cycle (`wb_we`=0 three cycles later).

Source files
------------

// File: rtl/rf_forward_unit.sv
// ============================================================================
// Module   : rf_forward_unit
// Brief    : Register file with EX/MEM/WB tag tracking, operand forwarding
//            and load-use stall detection for the miniRV pipeline.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rf_forward_unit #(
    parameter int NREG = 32,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_rs1_used,
    input  logic            id_rs2_used,
    input  logic [4:0]      id_rd,
    input  logic            id_we,
    input  logic [1:0]      id_wsel,
    input  logic            flush,
    input  logic [XLEN-1:0] ex_wd,
    input  logic [XLEN-1:0] mem_wd,
    input  logic [XLEN-1:0] wb_wd,
    output logic [XLEN-1:0] rD1,
    output logic [XLEN-1:0] rD2,
    output logic            load_use_stall,
    output logic            wb_we,
    output logic [4:0]      wb_rd
);

    localparam logic [1:0] c_wsel_mem = 2'b01;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       we;
        logic [1:0] wsel;
    } tag_t;

    tag_t ex_q, ex_d;
    tag_t mem_q, mem_d;
    tag_t wb_q, wb_d;

    logic [XLEN-1:0] rf_q [NREG];
    logic [XLEN-1:0] rf_d [NREG];

    logic ld_hit1, ld_hit2;

    function automatic logic stage_writes(input tag_t t, input logic [4:0] r);
        return t.v & t.we & (t.rd == r) & (r != 5'd0);
    endfunction

    // Youngest matching stage wins; a load still in EX is unresolved, so
    // the stored value is returned and the stall hides it.
    function automatic logic [XLEN-1:0] fwd(
        input logic [4:0]      rs,
        input tag_t            ex_t,
        input tag_t            mem_t,
        input tag_t            wb_t,
        input logic [XLEN-1:0] ex_val,
        input logic [XLEN-1:0] mem_val,
        input logic [XLEN-1:0] wb_val,
        input logic [XLEN-1:0] rf_val
    );
        if (rs == 5'd0)
            return '0;
        else if (stage_writes(ex_t, rs))
            return (ex_t.wsel != c_wsel_mem) ? ex_val : rf_val;
        else if (stage_writes(mem_t, rs))
            return mem_val;
        else if (stage_writes(wb_t, rs))
            return wb_val;
        else
            return rf_val;
    endfunction

    always_comb begin
        ld_hit1 = stage_writes(ex_q, id_rs1) & (ex_q.wsel == c_wsel_mem);
        ld_hit2 = stage_writes(ex_q, id_rs2) & (ex_q.wsel == c_wsel_mem);
        // A flushed decode instruction is discarded anyway, so it never stalls.
        load_use_stall = id_valid & ~flush &
                         ((id_rs1_used & ld_hit1) | (id_rs2_used & ld_hit2));
    end

    always_comb begin
        rD1 = fwd(id_rs1, ex_q, mem_q, wb_q, ex_wd, mem_wd, wb_wd, rf_q[id_rs1]);
        rD2 = fwd(id_rs2, ex_q, mem_q, wb_q, ex_wd, mem_wd, wb_wd, rf_q[id_rs2]);
    end

    always_comb begin
        wb_we = wb_q.v & wb_q.we & (wb_q.rd != 5'd0);
        wb_rd = wb_q.rd;
    end

    always_comb begin
        ex_d = '0;
        if (id_valid && !flush && !load_use_stall) begin
            ex_d.v    = 1'b1;
            ex_d.rd   = id_rd;
            ex_d.we   = id_we;
            ex_d.wsel = id_wsel;
        end
        mem_d = ex_q;
        wb_d  = mem_q;
    end

    always_comb begin
        rf_d = rf_q;
        if (wb_we)
            rf_d[wb_q.rd] = wb_wd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            for (int i = 0; i < NREG; i++)
                rf_q[i] <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            rf_q  <= rf_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rf_forward_unit.sv
// ============================================================================
// Module   : tb_rf_forward_unit
// Brief    : Directed self-checking bench for rf_forward_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rf_forward_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_rs1_used, id_rs2_used, id_we;
    logic [1:0]  id_wsel;
    logic        flush;
    logic [31:0] ex_wd, mem_wd, wb_wd;
    logic [31:0] rD1, rD2;
    logic        load_use_stall, wb_we;
    logic [4:0]  wb_rd;

    int checks = 0;
    int errors = 0;

    rf_forward_unit #(.NREG(32), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_we(id_we), .id_wsel(id_wsel), .flush(flush),
        .ex_wd(ex_wd), .mem_wd(mem_wd), .wb_wd(wb_wd),
        .rD1(rD1), .rD2(rD2), .load_use_stall(load_use_stall),
        .wb_we(wb_we), .wb_rd(wb_rd)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd, input logic we,
                         input logic [1:0] wsel, input logic fl);
        id_valid = v; id_rs1 = rs1; id_rs1_used = u1;
        id_rs2 = rs2; id_rs2_used = u2;
        id_rd = rd; id_we = we; id_wsel = wsel; flush = fl;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        ex_wd = 32'h0; mem_wd = 32'h0; wb_wd = 32'h0;
        id_rs1 = 5'd5; id_rs2 = 5'd7;
        tick(); tick();
        #1;
        checks++; if (rD1 !== 32'h0) begin errors++; $display("FAIL reset_rd1: got %h want %h", rD1, 32'h0); end
        checks++; if (rD2 !== 32'h0) begin errors++; $display("FAIL reset_rd2: got %h want %h", rD2, 32'h0); end
        checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", load_use_stall); end
        checks++; if (wb_we !== 1'b0 || wb_rd !== 5'd0) begin errors++; $display("FAIL reset_wb: got we=%b rd=%0d want we=0 rd=0", wb_we, wb_rd); end
        rst = 1'b0;
        tick();

        // Put a write to x5 into WB, then reset before it commits.
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 2'b00, 1'b0);
        tick();
        idle();
        tick(); tick();
        wb_wd = 32'h55; id_rs1 = 5'd5;
        #1;
        checks++; if (wb_we !== 1'b1 || wb_rd !== 5'd5) begin errors++; $display("FAIL midrun_wb: got we=%b rd=%0d want we=1 rd=5", wb_we, wb_rd); end
        checks++; if (rD1 !== 32'h55) begin errors++; $display("FAIL midrun_wb_bypass: got %h want %h", rD1, 32'h55); end
        rst = 1'b1;
        #1;
        checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL async_reset_we: got %b want 0", wb_we); end
        checks++; if (rD1 !== 32'h0) begin errors++; $display("FAIL async_reset_rd1: got %h want %h", rD1, 32'h0); end
        tick();
        rst = 1'b0;
        wb_wd = 32'h0;
        tick();
        checks++; if (rD1 !== 32'h0) begin errors++; $display("FAIL reset_dropped_write: got %h want %h", rD1, 32'h0); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 2'b00, 1'b0);
        tick();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0);
        ex_wd = 32'h11; mem_wd = 32'h77; wb_wd = 32'h66;
        #1;
        checks++; if (rD1 !== 32'h11) begin errors++; $display("FAIL b2b_ex_fwd: got %h want %h", rD1, 32'h11); end
        checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL b2b_no_stall: got %b want 0", load_use_stall); end
        tick();
        drive(1'b0, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0);
        ex_wd = 32'h999; mem_wd = 32'h11;
        #1;
        checks++; if (rD1 !== 32'h11) begin errors++; $display("FAIL b2b_mem_fwd: got %h want %h", rD1, 32'h11); end
        tick();
        mem_wd = 32'h888; wb_wd = 32'h11;
        #1;
        checks++; if (rD1 !== 32'h11) begin errors++; $display("FAIL b2b_wb_fwd: got %h want %h", rD1, 32'h11); end
        checks++; if (wb_we !== 1'b1 || wb_rd !== 5'd1) begin errors++; $display("FAIL b2b_wb_tag: got we=%b rd=%0d want we=1 rd=1", wb_we, wb_rd); end
        tick();
        wb_wd = 32'h444;
        #1;
        checks++; if (rD1 !== 32'h11) begin errors++; $display("FAIL b2b_rf_read: got %h want %h", rD1, 32'h11); end
    endtask

    task automatic test_load_use();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 2'b01, 1'b0);
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 5'd0, 1'b0, 2'b00, 1'b0);
        ex_wd = 32'h12345678; mem_wd = 32'h0; wb_wd = 32'h0;
        #1;
        checks++; if (load_use_stall !== 1'b1) begin errors++; $display("FAIL load_use_stall: got %b want 1", load_use_stall); end
        tick();
        mem_wd = 32'hDEADBEEF;
        #1;
        checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL load_use_release: got %b want 0", load_use_stall); end
        checks++; if (rD2 !== 32'hDEADBEEF) begin errors++; $display("FAIL load_use_mem_fwd: got %h want %h", rD2, 32'hDEADBEEF); end
        tick();
        idle();
        wb_wd = 32'hDEADBEEF;
        tick();
        wb_wd = 32'h0;
        tick(); tick();
    endtask

    task automatic test_priority();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 2'b00, 1'b0);
            tick();
        end
        drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 2'b00, 1'b1);
        ex_wd = 32'hA; mem_wd = 32'hB; wb_wd = 32'hC;
        #1;
        checks++; if (rD1 !== 32'hA) begin errors++; $display("FAIL prio_ex: got %h want %h", rD1, 32'hA); end
        tick();
        ex_wd = 32'h0E0; mem_wd = 32'hA; wb_wd = 32'hB;
        #1;
        checks++; if (rD1 !== 32'hA) begin errors++; $display("FAIL prio_mem: got %h want %h", rD1, 32'hA); end
        tick();
        mem_wd = 32'h0E1; wb_wd = 32'hA;
        #1;
        checks++; if (rD1 !== 32'hA) begin errors++; $display("FAIL prio_wb: got %h want %h", rD1, 32'hA); end
        tick();
        wb_wd = 32'h0E2;
        #1;
        checks++; if (rD1 !== 32'hA) begin errors++; $display("FAIL prio_rf: got %h want %h", rD1, 32'hA); end
        idle();
    endtask

    task automatic test_x0_unused();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 2'b00, 1'b0);
        ex_wd = 32'hFF;
        tick();
        idle();
        mem_wd = 32'hFF;
        tick();
        wb_wd = 32'hFF;
        tick();
        #1;
        checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL x0_wb_we: got %b want 0", wb_we); end
        checks++; if (rD1 !== 32'h0) begin errors++; $display("FAIL x0_read_wb: got %h want %h", rD1, 32'h0); end
        tick();
        checks++; if (rD1 !== 32'h0) begin errors++; $display("FAIL x0_read_rf: got %h want %h", rD1, 32'h0); end

        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 2'b01, 1'b0);
        tick();
        drive(1'b1, 5'd4, 1'b0, 5'd4, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0);
        #1;
        checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL unused_no_stall: got %b want 0", load_use_stall); end
        id_rs2_used = 1'b1;
        #1;
        checks++; if (load_use_stall !== 1'b1) begin errors++; $display("FAIL used_rs2_stall: got %b want 1", load_use_stall); end
        idle();
        tick(); tick(); tick(); tick();
    endtask

    task automatic test_flush_stall();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 2'b01, 1'b0);
        tick();
        drive(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 2'b00, 1'b1);
        #1;
        checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL flush_over_stall: got %b want 0", load_use_stall); end
        tick();
        idle();
        tick();
        #1;
        checks++; if (wb_we !== 1'b1 || wb_rd !== 5'd6) begin errors++; $display("FAIL flush_load_wb: got we=%b rd=%0d want we=1 rd=6", wb_we, wb_rd); end
        tick();
        checks++; if (wb_we !== 1'b0 || wb_rd !== 5'd0) begin errors++; $display("FAIL flush_bubble_wb: got we=%b rd=%0d want we=0 rd=0", wb_we, wb_rd); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_use();
        test_priority();
        test_x0_unused();
        test_flush_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
